// File: rtl/epochtv1_vram_arb.sv
// VRAM bank arbiter for the Epoch TV-1: shares one external bank between CPU and renderer,
// one access per CE slot, renderer first with a starvation guard that forces a CPU slot.
module epochtv1_vram_arb #(
  parameter int AWIDTH       = 12,
  parameter int DWIDTH       = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_ce,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [AWIDTH-1:0] i_cpu_a,
  input  logic [DWIDTH-1:0] i_cpu_di,
  output logic [DWIDTH-1:0] o_cpu_do,
  output logic              o_cpu_ack,
  input  logic              i_ren_req,
  input  logic [AWIDTH-1:0] i_ren_a,
  output logic              o_ren_gnt,
  output logic [DWIDTH-1:0] o_ren_do,
  output logic              o_ren_rvalid,
  output logic [AWIDTH-1:0] o_va,
  input  logic [DWIDTH-1:0] i_vd,
  output logic [DWIDTH-1:0] o_vd,
  output logic              o_nvrd,
  output logic              o_nvwr
);

  localparam int CW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAXC = CW'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_count, w_count_next;
  logic                w_gnt_ren, w_gnt_cpu;
  logic                r_sel_cpu, r_we;
  logic [AWIDTH-1:0]   r_va;
  logic [DWIDTH-1:0]   r_vd, r_cpu_do, r_ren_do;
  logic                r_nvrd, r_nvwr, r_ack, r_gnt, r_rvalid;

  // Count stays at MAXC while the renderer keeps winning, so "!= MAXC" means "< MAXC".
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_gnt_ren    = 1'b0;
    w_gnt_cpu    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_ce) begin
          if (i_cpu_req && (!i_ren_req || r_count == MAXC)) begin
            w_gnt_cpu    = 1'b1;
            w_count_next = '0;
          end else if (i_ren_req) begin
            w_gnt_ren = 1'b1;
            if (i_cpu_req) w_count_next = CW'(r_count + 1'b1);
          end
          if (w_gnt_cpu || w_gnt_ren) w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_sel_cpu <= 1'b0;
      r_we      <= 1'b0;
      r_va      <= '0;
      r_vd      <= '0;
      r_cpu_do  <= '0;
      r_ren_do  <= '0;
      r_nvrd    <= 1'b1;
      r_nvwr    <= 1'b1;
      r_ack     <= 1'b0;
      r_gnt     <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_gnt    <= w_gnt_ren;
      r_ack    <= 1'b0;
      r_rvalid <= 1'b0;
      if (w_gnt_ren) begin
        r_va      <= i_ren_a;
        r_nvrd    <= 1'b0;
        r_sel_cpu <= 1'b0;
        r_we      <= 1'b0;
      end
      if (w_gnt_cpu) begin
        r_va      <= i_cpu_a;
        r_sel_cpu <= 1'b1;
        r_we      <= i_cpu_we;
        if (i_cpu_we) begin
          r_vd   <= i_cpu_di;
          r_nvwr <= 1'b0;
        end else begin
          r_nvrd <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_nvrd <= 1'b1;
        r_nvwr <= 1'b1;
      end
      // Read data is captured one CLK after the strobe closes, giving the RAM a full cycle.
      if (r_state == ST_DONE) begin
        if (r_sel_cpu) begin
          r_ack <= 1'b1;
          if (!r_we) r_cpu_do <= i_vd;
        end else begin
          r_rvalid <= 1'b1;
          r_ren_do <= i_vd;
        end
      end
    end
  end

  assign o_va         = r_va;
  assign o_vd         = r_vd;
  assign o_nvrd       = r_nvrd;
  assign o_nvwr       = r_nvwr;
  assign o_cpu_do     = r_cpu_do;
  assign o_cpu_ack    = r_ack;
  assign o_ren_gnt    = r_gnt;
  assign o_ren_do     = r_ren_do;
  assign o_ren_rvalid = r_rvalid;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Bench for epochtv1_vram_arb: directed scenarios plus a randomized slot-level reference model.
module tb_epochtv1_vram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, cpu_req, cpu_we, ren_req, load;
  logic [11:0] cpu_a, ren_a;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do, ren_do, vd_i, vd_o;
  logic        cpu_ack, ren_gnt, ren_rvalid, nvrd, nvwr;
  logic [11:0] va;

  logic        cpu_req0, ren_req0;
  logic [7:0]  cpu_do0, ren_do0, vd_i0, vd_o0;
  logic        cpu_ack0, ren_gnt0, ren_rvalid0, nvrd0, nvwr0;
  logic [11:0] va0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  assign vd_i  = mem[va];
  assign vd_i0 = mem[va0];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else if (nvwr === 1'b0) begin
      mem[va] <= vd_o;
    end
  end

  epochtv1_vram_arb #(.AWIDTH(12), .DWIDTH(8), .CPU_MAX_WAIT(4)) dut (
    .i_clk(clk), .i_res(rst), .i_ce(ce),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_a(cpu_a), .i_cpu_di(cpu_di),
    .o_cpu_do(cpu_do), .o_cpu_ack(cpu_ack),
    .i_ren_req(ren_req), .i_ren_a(ren_a), .o_ren_gnt(ren_gnt),
    .o_ren_do(ren_do), .o_ren_rvalid(ren_rvalid),
    .o_va(va), .i_vd(vd_i), .o_vd(vd_o), .o_nvrd(nvrd), .o_nvwr(nvwr)
  );

  epochtv1_vram_arb #(.AWIDTH(12), .DWIDTH(8), .CPU_MAX_WAIT(0)) dut0 (
    .i_clk(clk), .i_res(rst), .i_ce(ce),
    .i_cpu_req(cpu_req0), .i_cpu_we(cpu_we), .i_cpu_a(cpu_a), .i_cpu_di(cpu_di),
    .o_cpu_do(cpu_do0), .o_cpu_ack(cpu_ack0),
    .i_ren_req(ren_req0), .i_ren_a(ren_a), .o_ren_gnt(ren_gnt0),
    .o_ren_do(ren_do0), .o_ren_rvalid(ren_rvalid0),
    .o_va(va0), .i_vd(vd_i0), .o_vd(vd_o0), .o_nvrd(nvrd0), .o_nvwr(nvwr0)
  );

  typedef struct {
    logic        g_gnt, g_nvrd, g_nvwr;
    logic [11:0] g_va;
    logic [7:0]  g_vdo;
    logic        m_gnt, m_nvrd, m_nvwr;
    logic        d_ack, d_rvalid;
    logic [7:0]  d_cpu_do, d_ren_do;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CE slot observed at the grant edge G, at G+1 and at G+2; requesters behave per protocol.
  task automatic run_slot(input logic extra_ce, output obs_t o);
    ce = 1'b1;
    tick();
    o.g_gnt = ren_gnt; o.g_nvrd = nvrd; o.g_nvwr = nvwr; o.g_va = va; o.g_vdo = vd_o;
    if (ren_gnt === 1'b1) ren_req = 1'b0;
    ce = extra_ce;
    tick();
    o.m_gnt = ren_gnt; o.m_nvrd = nvrd; o.m_nvwr = nvwr;
    ce = 1'b0;
    tick();
    o.d_ack = cpu_ack; o.d_rvalid = ren_rvalid; o.d_cpu_do = cpu_do; o.d_ren_do = ren_do;
    if (cpu_ack === 1'b1) cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      ren_req = 1'($urandom); cpu_a = 12'($urandom); ren_a = 12'($urandom);
      cpu_di = 8'($urandom);
      tick();
      checks++;
      if (nvrd !== 1'b1 || nvwr !== 1'b1) begin
        errors++; $display("FAIL reset_strobes cyc %0d: nvrd=%b nvwr=%b want 1 1", i, nvrd, nvwr);
      end
      checks++;
      if ({cpu_ack, ren_gnt, ren_rvalid} !== 3'b000) begin
        errors++; $display("FAIL reset_pulses cyc %0d: ack/gnt/rvalid=%b want 000", i, {cpu_ack, ren_gnt, ren_rvalid});
      end
      checks++;
      if ({va, vd_o, cpu_do, ren_do} !== 36'd0) begin
        errors++; $display("FAIL reset_data cyc %0d: va=%h vd_o=%h cpu_do=%h ren_do=%h want 0", i, va, vd_o, cpu_do, ren_do);
      end
    end
    ce = 0; cpu_req = 0; cpu_we = 0; ren_req = 0; cpu_a = 0; ren_a = 0; cpu_di = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_renderer_only();
    obs_t o;
    ren_req = 1'b1; ren_a = 12'h123;
    run_slot(1'b0, o);
    checks++;
    if (o.g_gnt !== 1'b1 || o.g_nvrd !== 1'b0 || o.g_nvwr !== 1'b1 || o.g_va !== 12'h123) begin
      errors++; $display("FAIL ren_issue: gnt=%b nvrd=%b nvwr=%b va=%h want 1 0 1 123", o.g_gnt, o.g_nvrd, o.g_nvwr, o.g_va);
    end
    checks++;
    if (o.m_gnt !== 1'b0 || o.m_nvrd !== 1'b1 || o.m_nvwr !== 1'b1) begin
      errors++; $display("FAIL ren_done: gnt=%b nvrd=%b nvwr=%b want 0 1 1", o.m_gnt, o.m_nvrd, o.m_nvwr);
    end
    checks++;
    if (o.d_rvalid !== 1'b1 || o.d_ren_do !== 8'h5A || o.d_ack !== 1'b0) begin
      errors++; $display("FAIL ren_data: rvalid=%b ren_do=%h ack=%b want 1 5a 0", o.d_rvalid, o.d_ren_do, o.d_ack);
    end
    tick();
    checks++;
    if (ren_rvalid !== 1'b0 || ren_do !== 8'h5A || va !== 12'h123) begin
      errors++; $display("FAIL ren_hold: rvalid=%b ren_do=%h va=%h want 0 5a 123", ren_rvalid, ren_do, va);
    end
    $display("renderer read 0x123 -> %h", o.d_ren_do);
  endtask

  task automatic test_cpu_write_read();
    obs_t o;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'hFFF; cpu_di = 8'h3C;
    run_slot(1'b0, o);
    ref_mem[12'hFFF] = 8'h3C;
    checks++;
    if (o.g_nvwr !== 1'b0 || o.g_nvrd !== 1'b1 || o.g_va !== 12'hFFF || o.g_vdo !== 8'h3C) begin
      errors++; $display("FAIL cpu_wr_issue: nvwr=%b nvrd=%b va=%h vd_o=%h want 0 1 fff 3c", o.g_nvwr, o.g_nvrd, o.g_va, o.g_vdo);
    end
    checks++;
    if (o.m_nvwr !== 1'b1 || o.d_ack !== 1'b1 || o.g_gnt !== 1'b0) begin
      errors++; $display("FAIL cpu_wr_done: nvwr_g1=%b ack_g2=%b gnt=%b want 1 1 0", o.m_nvwr, o.d_ack, o.g_gnt);
    end
    tick();
    checks++;
    if (mem[12'hFFF] !== 8'h3C || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_wr_mem: mem=%h ack=%b want 3c 0", mem[12'hFFF], cpu_ack);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'hFFF; cpu_di = 8'h00;
    run_slot(1'b0, o);
    checks++;
    if (o.g_nvrd !== 1'b0 || o.g_nvwr !== 1'b1 || o.d_ack !== 1'b1 || o.d_cpu_do !== 8'h3C) begin
      errors++; $display("FAIL cpu_rd: nvrd=%b nvwr=%b ack=%b cpu_do=%h want 0 1 1 3c", o.g_nvrd, o.g_nvwr, o.d_ack, o.d_cpu_do);
    end
    $display("cpu write/read 0xfff -> %h", o.d_cpu_do);
  endtask

  task automatic test_starvation();
    obs_t o;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h2A0;
    for (int s = 0; s < 6; s++) begin
      ren_req = 1'b1; ren_a = 12'($urandom);
      run_slot(1'b0, o);
      checks++;
      if (o.g_gnt !== (s != 4) || o.d_ack !== (s == 4) || o.d_rvalid !== (s != 4)) begin
        errors++; $display("FAIL starve slot %0d: gnt=%b ack=%b rvalid=%b want %b %b %b", s, o.g_gnt, o.d_ack, o.d_rvalid, s != 4, s == 4, s != 4);
      end
      if (s == 4) begin
        checks++;
        if (o.d_cpu_do !== ref_mem[12'h2A0] || o.g_va !== 12'h2A0) begin
          errors++; $display("FAIL starve_cpu_data: cpu_do=%h va=%h want %h 2a0", o.d_cpu_do, o.g_va, ref_mem[12'h2A0]);
        end
      end
      $display("starvation slot %0d: ren_gnt=%b cpu_ack=%b", s, o.g_gnt, o.d_ack);
    end
    ren_req = 1'b0; cpu_req = 1'b0;
    cpu_req0 = 1'b1; ren_req0 = 1'b1; cpu_a = 12'h2A0; cpu_we = 1'b0;
    ce = 1'b1;
    tick();
    checks++;
    if (ren_gnt0 !== 1'b0 || nvrd0 !== 1'b0 || va0 !== 12'h2A0) begin
      errors++; $display("FAIL strict_cpu_issue: gnt=%b nvrd=%b va=%h want 0 0 2a0", ren_gnt0, nvrd0, va0);
    end
    ce = 1'b0;
    tick(); tick();
    checks++;
    if (cpu_ack0 !== 1'b1 || cpu_do0 !== ref_mem[12'h2A0] || ren_rvalid0 !== 1'b0) begin
      errors++; $display("FAIL strict_cpu_done: ack=%b cpu_do=%h rvalid=%b want 1 %h 0", cpu_ack0, cpu_do0, ren_rvalid0, ref_mem[12'h2A0]);
    end
    cpu_req0 = 1'b0; ren_req0 = 1'b0;
    $display("strict priority first slot: cpu_ack=%b", cpu_ack0);
    tick();
  endtask

  task automatic test_lost_slot();
    obs_t o;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h3B1;
    ren_req = 1'b1; ren_a = 12'h010;
    run_slot(1'b1, o);
    checks++;
    if (o.g_gnt !== 1'b1 || o.m_gnt !== 1'b0 || o.m_nvrd !== 1'b1 || o.m_nvwr !== 1'b1 ||
        o.d_rvalid !== 1'b1 || o.d_ack !== 1'b0) begin
      errors++; $display("FAIL lost_ce: gnt=%b gnt_g1=%b nvrd_g1=%b nvwr_g1=%b rvalid=%b ack=%b want 1 0 1 1 1 0",
                         o.g_gnt, o.m_gnt, o.m_nvrd, o.m_nvwr, o.d_rvalid, o.d_ack);
    end
    for (int s = 1; s < 5; s++) begin
      ren_req = 1'b1;
      run_slot(1'b0, o);
      checks++;
      if (o.g_gnt !== (s != 4) || o.d_ack !== (s == 4)) begin
        errors++; $display("FAIL lost_count slot %0d: gnt=%b ack=%b want %b %b", s, o.g_gnt, o.d_ack, s != 4, s == 4);
      end
      $display("lost-slot follow-up %0d: ren_gnt=%b cpu_ack=%b", s, o.g_gnt, o.d_ack);
    end
    ren_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h055;
    ce = 1'b1;
    tick();
    checks++;
    if (nvrd !== 1'b0) begin
      errors++; $display("FAIL midrst_issue: nvrd=%b want 0", nvrd);
    end
    ce = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (nvrd !== 1'b1 || nvwr !== 1'b1) begin
      errors++; $display("FAIL midrst_async: nvrd=%b nvwr=%b want 1 1", nvrd, nvwr);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      checks++;
      if (cpu_ack !== 1'b0 || nvrd !== 1'b1) begin
        errors++; $display("FAIL midrst_noack cyc %0d: ack=%b nvrd=%b want 0 1", i, cpu_ack, nvrd);
      end
    end
    run_slot(1'b0, o);
    checks++;
    if (o.d_ack !== 1'b1 || o.d_cpu_do !== ref_mem[12'h055]) begin
      errors++; $display("FAIL midrst_retry: ack=%b cpu_do=%h want 1 %h", o.d_ack, o.d_cpu_do, ref_mem[12'h055]);
    end
    $display("re-request after reset: ack=%b cpu_do=%h", o.d_ack, o.d_cpu_do);
    cpu_req = 1'b0;
  endtask

  // Slot-level model: who wins each slot and what data the winner must see.
  task automatic test_random(input int n);
    obs_t o;
    int   wait_cnt;
    logic e_ren, e_cpu, t_we;
    logic [11:0] t_ca, t_ra;
    logic [7:0]  t_di;
    wait_cnt = 0;
    for (int s = 0; s < n; s++) begin
      if (!ren_req && ($urandom_range(0, 2) != 0)) begin
        ren_req = 1'b1; ren_a = 12'($urandom_range(0, 31));
      end
      if (!cpu_req && ($urandom_range(0, 4) < 2)) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_a = 12'($urandom_range(0, 31)); cpu_di = 8'($urandom);
      end
      e_cpu = cpu_req && (!ren_req || wait_cnt >= 4);
      e_ren = ren_req && !e_cpu;
      if (e_cpu) wait_cnt = 0;
      else if (e_ren && cpu_req) wait_cnt++;
      t_we = cpu_we; t_ca = cpu_a; t_ra = ren_a; t_di = cpu_di;
      run_slot(1'b0, o);
      checks++;
      if (o.g_gnt !== e_ren || o.d_rvalid !== e_ren || o.d_ack !== e_cpu) begin
        errors++; $display("FAIL rand_owner slot %0d: gnt=%b rvalid=%b ack=%b want %b %b %b", s, o.g_gnt, o.d_rvalid, o.d_ack, e_ren, e_ren, e_cpu);
      end
      checks++;
      if (o.g_nvrd !== !(e_ren || (e_cpu && !t_we)) || o.g_nvwr !== !(e_cpu && t_we) ||
          o.m_nvrd !== 1'b1 || o.m_nvwr !== 1'b1) begin
        errors++; $display("FAIL rand_strobes slot %0d: g=%b%b g1=%b%b", s, o.g_nvrd, o.g_nvwr, o.m_nvrd, o.m_nvwr);
      end
      if (e_ren) begin
        checks++;
        if (o.g_va !== t_ra || o.d_ren_do !== ref_mem[t_ra]) begin
          errors++; $display("FAIL rand_ren slot %0d: va=%h ren_do=%h want %h %h", s, o.g_va, o.d_ren_do, t_ra, ref_mem[t_ra]);
        end
      end
      if (e_cpu) begin
        checks++;
        if (o.g_va !== t_ca || (t_we && o.g_vdo !== t_di) || (!t_we && o.d_cpu_do !== ref_mem[t_ca])) begin
          errors++; $display("FAIL rand_cpu slot %0d: va=%h vd_o=%h cpu_do=%h want %h %h %h", s, o.g_va, o.g_vdo, o.d_cpu_do, t_ca, t_di, ref_mem[t_ca]);
        end
        if (t_we) ref_mem[t_ca] = t_di;
      end
      $display("rand slot %0d: ren=%b cpu=%b we=%b va=%h", s, e_ren, e_cpu, t_we, o.g_va);
    end
    ren_req = 1'b0; cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; ce = 0; cpu_req = 0; cpu_we = 0; ren_req = 0;
    cpu_a = 0; ren_a = 0; cpu_di = 0; cpu_req0 = 0; ren_req0 = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h123] = 8'h5A;
    test_reset();
    test_renderer_only();
    test_cpu_write_read();
    test_starvation();
    test_lost_slot();
    test_reset_mid();
    test_random(150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
